// File: rtl/wave_period_meter_pkg.sv
// Shared definitions for the wave period meter: FSM state encodings and the default count width.
// The state encodings are fixed (IDLE=0, MEAS_HIGH=1, MEAS_LOW=2) so that the wave generator and
// checker benches can decode them.
package wave_period_meter_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMeasHigh = 2'd1,
    StMeasLow  = 2'd2
  } state_e;

endpackage

// File: rtl/wave_period_meter_sync_edge.sv
// Synchronizer and edge detector for the asynchronous wave input.
// Optional glitch filter when WAVE_GLITCH_FILTER_EN is defined: the filtered level follows the
// synchronized level only after it has differed for GLITCH_N consecutive cycles.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   wave_in  in  asynchronous wave
//   rise     out one-cycle pulse on a rising edge of the (filtered) synchronized level
//   fall     out one-cycle pulse on a falling edge of the (filtered) synchronized level
module wave_period_meter_sync_edge #(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned GLITCH_N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic wave_in,
  output logic rise,
  output logic fall
);

  if (SYNC_STG < 2 || SYNC_STG > 4) begin : g_bad_sync_stg
    $error("SYNC_STG must be in 2..4");
  end
  if (GLITCH_N < 1) begin : g_bad_glitch_n
    $error("GLITCH_N must be at least 1");
  end

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                lvl;
  logic                lvl_q, lvl_d;

  assign sync_d = {sync_q[SYNC_STG-2:0], wave_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef WAVE_GLITCH_FILTER_EN
  localparam int unsigned GlW = $clog2(GLITCH_N + 1);

  logic           filt_q, filt_d;
  logic [GlW-1:0] gcnt_q, gcnt_d;

  // Count consecutive cycles where the raw level disagrees with the filtered one; any agreement
  // restarts the count, so pulses shorter than GLITCH_N never reach the filtered level.
  always_comb begin
    filt_d = filt_q;
    gcnt_d = '0;
    if (sync_q[SYNC_STG-1] != filt_q) begin
      if (gcnt_q == GlW'(GLITCH_N - 1)) begin
        filt_d = sync_q[SYNC_STG-1];
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STG-1];
`endif

  assign lvl_d = lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/wave_period_meter.sv
// Wave period meter: measures each rising-to-rising period of an asynchronous wave as separate
// high and low cycle counts and reports one result per period over valid/ready.
// Optional glitch filter selected by defining WAVE_GLITCH_FILTER_EN.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   wave_in    in   asynchronous wave under measurement
//   enable     in   1 = measure, 0 = return to idle and discard the partial period
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer ready
//   high_cnt   out  high-time count of the reported period
//   low_cnt    out  low-time count of the reported period
//   overrun    out  sticky: a result was dropped while one was pending
//   sat        out  the reported result contains a saturated count
module wave_period_meter
  import wave_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned GLITCH_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wave_in,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             overrun,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic rise, fall, publish;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  wave_period_meter_sync_edge #(
    .SYNC_STG (SYNC_STG),
    .GLITCH_N (GLITCH_N)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .wave_in (wave_in),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    out_valid_d = out_valid_q;
    high_d      = high_q;
    low_d       = low_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;
    publish     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StMeasHigh;
          hcnt_d  = CntOne;
          lcnt_d  = '0;
        end
      end
      StMeasHigh: begin
        if (fall) begin
          state_d = StMeasLow;
          lcnt_d  = CntOne;
        end else if (hcnt_q != CntMax) begin
          hcnt_d = hcnt_q + CntOne;
        end
      end
      StMeasLow: begin
        // A rise closes this period and opens the next one in the same cycle.
        if (rise) begin
          publish = 1'b1;
          state_d = StMeasHigh;
          hcnt_d  = CntOne;
          lcnt_d  = '0;
        end else if (lcnt_q != CntMax) begin
          lcnt_d = lcnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      state_d = StIdle;
      hcnt_d  = '0;
      lcnt_d  = '0;
      publish = 1'b0;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Load when the output slot is free or is being emptied this cycle; otherwise drop.
    if (publish) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        high_d      = hcnt_q;
        low_d       = lcnt_q;
        sat_d       = (hcnt_q == CntMax) || (lcnt_q == CntMax);
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      out_valid_q <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      out_valid_q <= out_valid_d;
      high_q      <= high_d;
      low_q       <= low_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign high_cnt  = high_q;
  assign low_cnt   = low_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter: a 16-bit instance for the main scenarios and a 4-bit
// instance for count saturation. Accepted results are collected into a queue by a monitor.
module tb_wave_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wave_in, enable, out_ready;
  logic        out_valid, overrun, sat;
  logic [15:0] high_cnt, low_cnt;

  logic        wave4, ready4;
  logic        valid4, overrun4, sat4;
  logic [3:0]  high4, low4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int h;
    int l;
    int s;
  } res_t;
  res_t q[$];

  wave_period_meter u_dut (
    .clk       (clk),
    .rst       (rst),
    .wave_in   (wave_in),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt),
    .overrun   (overrun),
    .sat       (sat)
  );

  wave_period_meter #(
    .CNT_W (4)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .wave_in   (wave4),
    .enable    (enable),
    .out_valid (valid4),
    .out_ready (ready4),
    .high_cnt  (high4),
    .low_cnt   (low4),
    .overrun   (overrun4),
    .sat       (sat4)
  );

  always #5 clk = ~clk;

  // Inputs change 1 unit after a rising edge, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      q.push_back('{int'(high_cnt), int'(low_cnt), int'(sat)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int idx, input int h, input int l, input int s);
    if (q.size() > idx) begin
      chk({tag, ".high"}, q[idx].h, h);
      chk({tag, ".low"}, q[idx].l, l);
      chk({tag, ".sat"}, q[idx].s, s);
    end
  endtask

  task automatic period(input int h, input int l);
    wave_in = 1'b1;
    cyc(h);
    wave_in = 1'b0;
    cyc(l);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wave_in   = 1'b0;
    wave4     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    ready4    = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    q.delete();
  endtask

  initial begin
    // Reset values
    rst       = 1'b1;
    wave_in   = 1'b0;
    wave4     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    ready4    = 1'b0;
    cyc(2);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.high_cnt", high_cnt, 0);
    chk("rst.low_cnt", low_cnt, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.sat", sat, 0);
    chk("rst.valid4", valid4, 0);
    rst = 1'b0;
    cyc(2);

    // 1: 20/20 wave, always ready
    enable    = 1'b1;
    out_ready = 1'b1;
    repeat (4) period(20, 20);
    cyc(10);
    chk("t1.count", q.size(), 3);
    for (int i = 0; i < 3; i++) chk_res($sformatf("t1.r%0d", i), i, 20, 20, 0);
    chk("t1.overrun", overrun, 0);

    // 2: consumer stalled across several periods
    do_reset();
    enable = 1'b1;
    period(5, 35);
    repeat (3) period(7, 33);
    chk("t2.held_valid", out_valid, 1);
    chk("t2.held_high", high_cnt, 5);
    chk("t2.held_low", low_cnt, 35);
    chk("t2.overrun", overrun, 1);
    chk("t2.none_accepted", q.size(), 0);
    out_ready = 1'b1;
    period(5, 35);
    period(5, 35);
    wave_in = 1'b1;
    cyc(10);
    chk("t2.count", q.size(), 4);
    chk_res("t2.r0", 0, 5, 35, 0);
    chk_res("t2.r1", 1, 7, 33, 0);
    chk_res("t2.r2", 2, 5, 35, 0);
    chk_res("t2.r3", 3, 5, 35, 0);
    chk("t2.overrun_sticky", overrun, 1);

    // 3: 4-bit counts, high time saturates
    do_reset();
    enable = 1'b1;
    wave4  = 1'b1;
    cyc(30);
    wave4 = 1'b0;
    cyc(10);
    wave4 = 1'b1;
    cyc(8);
    chk("t3.valid", valid4, 1);
    chk("t3.high", high4, 15);
    chk("t3.low", low4, 10);
    chk("t3.sat", sat4, 1);
    chk("t3.overrun", overrun4, 0);

    // 4: reset in the middle of a high phase
    do_reset();
    enable = 1'b1;
    period(20, 20);
    wave_in = 1'b1;
    cyc(10);
    chk("t4.pre_valid", out_valid, 1);
    chk("t4.pre_high", high_cnt, 20);
    rst = 1'b1;
    #1;
    chk("t4.rst_valid", out_valid, 0);
    chk("t4.rst_high", high_cnt, 0);
    chk("t4.rst_low", low_cnt, 0);
    chk("t4.rst_overrun", overrun, 0);
    chk("t4.rst_sat", sat, 0);
    cyc(4);
    wave_in = 1'b0;
    cyc(5);
    rst       = 1'b0;
    out_ready = 1'b1;
    cyc(15);
    period(20, 20);
    chk("t4.no_early_result", q.size(), 0);
    wave_in = 1'b1;
    cyc(10);
    chk("t4.count", q.size(), 1);
    chk_res("t4.r0", 0, 20, 20, 0);

    // 5: one-cycle low glitch inside a 40-cycle high
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    wave_in   = 1'b1;
    cyc(20);
    wave_in = 1'b0;
    cyc(1);
    wave_in = 1'b1;
    cyc(19);
    wave_in = 1'b0;
    cyc(40);
    wave_in = 1'b1;
    cyc(10);
`ifdef WAVE_GLITCH_FILTER_EN
    chk("t5.count", q.size(), 1);
    chk_res("t5.r0", 0, 40, 40, 0);
`else
    chk("t5.count", q.size(), 2);
    chk_res("t5.r0", 0, 20, 1, 0);
    chk_res("t5.r1", 1, 19, 40, 0);
`endif

    // 6: enable dropped mid-low discards the broken period
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    period(20, 20);
    wave_in = 1'b1;
    cyc(20);
    wave_in = 1'b0;
    cyc(5);
    chk("t6.pre_count", q.size(), 1);
    chk_res("t6.pre", 0, 20, 20, 0);
    q.delete();
    enable = 1'b0;
    cyc(10);
    enable = 1'b1;
    cyc(5);
    period(20, 20);
    period(20, 20);
    wave_in = 1'b1;
    cyc(10);
    chk("t6.count", q.size(), 2);
    chk_res("t6.r0", 0, 20, 20, 0);
    chk_res("t6.r1", 1, 20, 20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
